// File: rtl/semaforo_ctrl.sv
// Traffic-light phase controller: VERDE/AMARELO/VERMELHO with an
// optional PEDESTRE phase, driving a 2-bit phase code {A,B}.
// Ports: clk, rst_n (async low), en (advance), ped_req (button)
//        A/B (phase code), ped_pend (latched request), phase_tick
module semaforo_ctrl #(
  parameter int unsigned T_VERDE    = 8,
  parameter int unsigned T_AMARELO  = 3,
  parameter int unsigned T_VERMELHO = 6,
  parameter int unsigned T_PEDESTRE = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ped_req,
  output logic A,
  output logic B,
  output logic ped_pend,
  output logic phase_tick
);

  typedef enum logic [1:0] {
    VERDE    = 2'b00,
    AMARELO  = 2'b01,
    VERMELHO = 2'b10,
    PEDESTRE = 2'b11
  } state_t;

  localparam logic [15:0] LD_V = 16'(T_VERDE - 1);
  localparam logic [15:0] LD_A = 16'(T_AMARELO - 1);
  localparam logic [15:0] LD_R = 16'(T_VERMELHO - 1);
  localparam logic [15:0] LD_P = 16'(T_PEDESTRE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        tick_q, tick_d;
  logic        done;
  logic        serve;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    serve   = 1'b0;
    done    = en && (cnt_q == 16'd0);
    if (done) begin
      tick_d = 1'b1;
      unique case (state_q)
        VERDE: begin
          state_d = AMARELO;
          cnt_d   = LD_A;
        end
        AMARELO: begin
          state_d = VERMELHO;
          cnt_d   = LD_R;
        end
        VERMELHO: begin
          // registered flag only: a press on this edge waits a cycle
          if (pend_q) begin
            state_d = PEDESTRE;
            cnt_d   = LD_P;
            serve   = 1'b1;
          end else begin
            state_d = VERDE;
            cnt_d   = LD_V;
          end
        end
        PEDESTRE: begin
          state_d = VERDE;
          cnt_d   = LD_V;
        end
        default: begin
          state_d = VERDE;
          cnt_d   = LD_V;
        end
      endcase
    end else if (en) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // entering PEDESTRE clears the flag even if the button is held
  always_comb begin
    pend_d = pend_q;
    if (serve)        pend_d = 1'b0;
    else if (ped_req) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VERDE;
      cnt_q   <= LD_V;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

  assign A          = state_q[1];
  assign B          = state_q[0];
  assign ped_pend   = pend_q;
  assign phase_tick = tick_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench for semaforo_ctrl: reference model feeds a
// scoreboard queue; directed steps cover phases, pedestrian, en, reset.
module tb_semaforo_ctrl;

  logic clk;
  logic rst_n;
  logic en;
  logic ped_req;
  logic A, B, ped_pend, phase_tick;
  logic A1, B1, pp1, tk1;
  logic one;

  semaforo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .A(A), .B(B), .ped_pend(ped_pend), .phase_tick(phase_tick)
  );

  semaforo_ctrl #(
    .T_VERDE(1), .T_AMARELO(1), .T_VERMELHO(1), .T_PEDESTRE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(one),
    .A(A1), .B(B1), .ped_pend(pp1), .phase_tick(tk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb[$];
  logic [1:0] m_st;
  int         m_cnt;
  logic       m_pend;
  logic       m_tick;

  function automatic int tlen(input logic [1:0] s);
    case (s)
      2'd0:    return 8;
      2'd1:    return 3;
      2'd2:    return 6;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 2'd0;
    m_cnt  = 7;
    m_pend = 1'b0;
    m_tick = 1'b0;
  endtask

  task automatic step(input logic e, input logic r);
    logic [1:0] ns;
    logic       clr;
    logic [3:0] exp;
    en      = e;
    ped_req = r;
    clr     = 1'b0;
    if (e && m_cnt == 0) begin
      case (m_st)
        2'd0: ns = 2'd1;
        2'd1: ns = 2'd2;
        2'd2: ns = m_pend ? 2'd3 : 2'd0;
        default: ns = 2'd0;
      endcase
      clr    = (ns == 2'd3);
      m_st   = ns;
      m_cnt  = tlen(ns) - 1;
      m_tick = 1'b1;
    end else begin
      if (e) m_cnt = m_cnt - 1;
      m_tick = 1'b0;
    end
    if (clr)    m_pend = 1'b0;
    else if (r) m_pend = 1'b1;
    sb.push_back({m_st, m_pend, m_tick});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    chk("outputs", int'({A, B, ped_pend, phase_tick}), int'(exp));
  endtask

  initial begin
    int ticks[$];
    int occ;
    int n;
    one     = 1'b1;
    rst_n   = 1'b0;
    en      = 1'b0;
    ped_req = 1'b0;
    model_reset();
    #2;
    chk("reset_async", int'({A, B, ped_pend, phase_tick}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    chk("rst_release", int'({A, B, ped_pend, phase_tick}), 0);

    // free-running cycle, ticks at 8, 11, 17
    for (int i = 1; i <= 34; i++) begin
      step(1'b1, 1'b0);
      if (phase_tick) ticks.push_back(i);
    end
    chk("tick_count", ticks.size(), 6);
    if (ticks.size() >= 3) begin
      chk("tick0", ticks[0], 8);
      chk("tick1", ticks[1], 11);
      chk("tick2", ticks[2], 17);
    end

    // pedestrian pulse during VERDE
    step(1'b1, 1'b1);
    chk("pend_set", int'(ped_pend), 1);
    n = 0;
    while (m_st != 2'd3 && n < 40) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("ped_phase", int'({A, B}), 3);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);

    // en low mid-AMARELO
    occ = 0;
    n = 0;
    while (!({A, B} == 2'b01) && n < 40) begin
      step(1'b1, 1'b0);
      n++;
    end
    if ({A, B} == 2'b01) occ++;
    step(1'b1, 1'b0);
    if ({A, B} == 2'b01) occ++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      if ({A, B} == 2'b01) occ++;
    end
    n = 0;
    while ({A, B} == 2'b01 && n < 20) begin
      step(1'b1, 1'b0);
      if ({A, B} == 2'b01) occ++;
      n++;
    end
    chk("amarelo_occ", occ, 7);

    // press exactly on the VERMELHO exit edge
    n = 0;
    while (!(m_st == 2'd2 && m_cnt == 0) && n < 40) begin
      step(1'b1, 1'b0);
      n++;
    end
    step(1'b1, 1'b1);
    chk("late_press_ab", int'({A, B}), 0);
    chk("late_press_pend", int'(ped_pend), 1);
    n = 0;
    while (m_st != 2'd3 && n < 40) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("late_press_ped", int'({A, B, ped_pend}), 6);

    // reset mid-VERMELHO with a pending request
    step(1'b1, 1'b1);
    n = 0;
    while (m_st != 2'd2 && n < 40) begin
      step(1'b1, 1'b0);
      n++;
    end
    step(1'b1, 1'b0);
    chk("pre_rst_pend", int'({A, B, ped_pend}), 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", int'({A, B, ped_pend, phase_tick}), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rel", int'({A, B, ped_pend, phase_tick}), 0);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0);
      chk("t1_ab", int'({A1, B1}), i % 4);
      chk("t1_tick", int'(tk1), 1);
    end
    chk("verde_full", int'({A, B}), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
